// File: rtl/cam_pkg.sv
// Shared types and geometry constants for the camera frame writer.
package cam_pkg;

  localparam int unsigned H_ACTIVE_DEFAULT = 640;
  localparam int unsigned V_ACTIVE_DEFAULT = 480;
  localparam int unsigned FRAME_PIXELS     = H_ACTIVE_DEFAULT * V_ACTIVE_DEFAULT;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned PIX_W  = 19;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } cam_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } portc_req_t;

  // Word address of a pixel inside a frame buffer; pix_idx never wraps the buffer.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [PIX_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/camera_frame_writer_if.sv
// SDRAM camera write port (portC) bundle driven by the frame writer.
interface camera_frame_writer_if;
  import cam_pkg::*;

  logic              portC_write;
  logic [ADDR_W-1:0] portC_addr;
  logic [DATA_W-1:0] portC_din;

  modport master (output portC_write, portC_addr, portC_din);
  modport slave  (input  portC_write, portC_addr, portC_din);

endinterface

// File: rtl/camera_frame_writer_edge_det.sv
// Registered previous-value edge detector; edges are combinational on the live input.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise_c = d & ~d_q;
  assign fall_c = ~d & d_q;

endmodule

// File: rtl/camera_frame_writer.sv
// Turns the camera pixel stream into portC SDRAM writes, double-buffering frames
// and publishing the base of the last well-formed frame as the VGA read offset.
module camera_frame_writer
  import cam_pkg::*;
#(
  parameter int unsigned       H_ACTIVE  = H_ACTIVE_DEFAULT,
  parameter int unsigned       V_ACTIVE  = V_ACTIVE_DEFAULT,
  parameter logic [ADDR_W-1:0] BUF0_BASE = 25'd0,
  parameter logic [ADDR_W-1:0] BUF1_BASE = 25'd524288
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic                  cam_valid,
  input  logic [DATA_W-1:0]     cam_data,
  camera_frame_writer_if.master portc,
  output logic [ADDR_W-1:0]     read_offset,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      frame_count
);

  localparam logic [X_W-1:0] H_LIM = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_LIM = Y_W'(V_ACTIVE);

  cam_state_e        state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] read_offset_d;
  logic [CNT_W-1:0]  frame_count_d;
  logic              frame_done_d, frame_err_d;
  logic              write_q, write_d;
  portc_req_t        req_q, req_d;

  logic vs_rise_c, vs_fall_c, href_fall_c, href_rise_unused, acc_c;

  edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (cam_vsync),
    .rise_c (vs_rise_c),
    .fall_c (vs_fall_c)
  );

  edge_det u_href_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (cam_href),
    .rise_c (href_rise_unused),
    .fall_c (href_fall_c)
  );

  assign acc_c = cam_href & cam_valid & ~cam_vsync & (state_q == CAPTURE);

  // Next-state and datapath; row end is applied before end-of-frame evaluation.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_d         = pix_q;
    err_d         = err_q;
    wr_base_d     = wr_base_q;
    read_offset_d = read_offset;
    frame_count_d = frame_count;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    write_d       = 1'b0;
    req_d         = req_q;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_SOF;
      end

      WAIT_SOF: begin
        if (vs_fall_c) begin
          state_d = CAPTURE;
          x_d     = '0;
          y_d     = '0;
          pix_d   = '0;
          err_d   = 1'b0;
        end
      end

      CAPTURE: begin
        if (acc_c) begin
          if ((x_q < H_LIM) && (y_q < V_LIM)) begin
            write_d   = 1'b1;
            req_d     = '{addr: pix_addr(wr_base_q, pix_q), din: cam_data};
            x_d       = x_q + X_W'(1);
            pix_d     = pix_q + PIX_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end

        if (href_fall_c) begin
          if (x_q != H_LIM) err_d = 1'b1;
          x_d = '0;
          if (y_q < V_LIM) y_d = y_q + Y_W'(1);
          else             err_d = 1'b1;
        end

        if (vs_rise_c) begin
          if (!err_d && (y_d == V_LIM)) begin
            read_offset_d = wr_base_q;
            wr_base_d     = (wr_base_q == BUF0_BASE) ? BUF1_BASE : BUF0_BASE;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count + CNT_W'(1);
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = enable ? WAIT_SOF : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      pix_q       <= '0;
      err_q       <= 1'b0;
      wr_base_q   <= BUF0_BASE;
      read_offset <= BUF1_BASE;
      frame_count <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      write_q     <= 1'b0;
      req_q       <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
      err_q       <= err_d;
      wr_base_q   <= wr_base_d;
      read_offset <= read_offset_d;
      frame_count <= frame_count_d;
      frame_done  <= frame_done_d;
      frame_err   <= frame_err_d;
      write_q     <= write_d;
      req_q       <= req_d;
    end
  end

  assign portc.portC_write = write_q;
  assign portc.portC_addr  = req_q.addr;
  assign portc.portC_din   = req_q.din;

endmodule
